// File: rtl/sipo_frame_pkg.sv
// Shared types for the serial-in/parallel-out framer.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package sipo_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } sipo_state_e;

  // Counter width able to hold the values 0..data_width inclusive.
  function automatic int cnt_w(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Shift-left assembly register for serial bits, MSB first.
// Latency: q reflects load/shift/clear on the following clk edge.
// Backpressure: none; every asserted command is applied.
// Ports: clk, resetn (sync, active-low); clear zeroes q; load writes bit_in at the LSB
//        with all other bits zero; shift moves q left and inserts bit_in at the LSB.
//        Priority is reset/clear, then load, then shift.
module sipo_shift_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  bit_in,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      q <= '0;
    end else if (load) begin
      q <= {{(DATA_WIDTH-1){1'b0}}, bit_in};
    end else if (shift) begin
      q <= {q[DATA_WIDTH-2:0], bit_in};
    end
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frames a serial bit stream into DATA_WIDTH-bit words with optional parity check.
// Latency: out_valid rises the cycle after the last bit (data or parity) is accepted.
// Backpressure: serial side has none; a word finishing while the holding register is full is dropped (overrun).
// Ports: clk, resetn (sync, active-low); sin_valid/sin_data/sin_start serial input;
//        out_valid/out_ready/out_data word output over a 1-entry holding register;
//        overrun, frame_err, parity_err are registered single-cycle event pulses.
module sipo_frame_ctrl
  import sipo_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  sin_valid,
  input  logic                  sin_data,
  input  logic                  sin_start,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  overrun,
  output logic                  frame_err,
  output logic                  parity_err
);

  localparam int             CW       = cnt_w(DATA_WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(DATA_WIDTH - 1);
  localparam logic           PAR_TGT  = 1'(PARITY_ODD);

  sipo_state_e     state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            par_acc, par_nxt;

  logic                  sr_clear, sr_load, sr_shift;
  logic [DATA_WIDTH-1:0] sr_q;

  logic                  word_vld;
  logic [DATA_WIDTH-1:0] word_dat;
  logic                  par_fail;
  logic                  start_err;
  logic                  drain;

  sipo_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift (
    .clk    (clk),
    .resetn (resetn),
    .clear  (sr_clear),
    .load   (sr_load),
    .shift  (sr_shift),
    .bit_in (sin_data),
    .q      (sr_q)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      par_acc <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      par_acc <= par_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    par_nxt   = par_acc;
    sr_clear  = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    word_vld  = 1'b0;
    word_dat  = sr_q;
    par_fail  = 1'b0;
    start_err = 1'b0;

    if (sin_valid) begin
      if (sin_start) begin
        // A start bit always opens a new frame; arriving mid-frame it also
        // abandons the partial word and flags the framing error.
        start_err = (state != IDLE);
        sr_load   = 1'b1;
        cnt_nxt   = CW'(1);
        par_nxt   = sin_data;
        state_nxt = SHIFT;
      end else begin
        case (state)
          SHIFT: begin
            sr_shift = 1'b1;
            cnt_nxt  = cnt + CW'(1);
            par_nxt  = par_acc ^ sin_data;
            if (cnt == LAST_CNT) begin
              if (PARITY_EN != 0) begin
                state_nxt = PARITY;
              end else begin
                // The shift register has not absorbed this bit yet, so
                // the word is formed from its current contents plus the bit.
                word_vld  = 1'b1;
                word_dat  = {sr_q[DATA_WIDTH-2:0], sin_data};
                sr_clear  = 1'b1;
                cnt_nxt   = '0;
                state_nxt = IDLE;
              end
            end
          end
          PARITY: begin
            sr_clear  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
            if ((par_acc ^ sin_data) == PAR_TGT) begin
              word_vld = 1'b1;
            end else begin
              par_fail = 1'b1;
            end
          end
          default: begin
            // IDLE: bits outside a frame are discarded.
          end
        endcase
      end
    end
  end

  assign drain = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      frame_err  <= start_err;
      parity_err <= par_fail;
      overrun    <= word_vld & out_valid & ~out_ready;
      // A slot being drained this cycle counts as free, so a word landing
      // on the drain edge replaces the old one without a bubble.
      if (word_vld && (!out_valid || out_ready)) begin
        out_data  <= word_dat;
        out_valid <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
